pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core. Drives the 6-bit stall vector and the jump/interrupt flush lines consumed by all pipeline registers, including the ID/EXE register.
- Resolves stall priority between ID, EXE and MEM, and sequences interrupt entry through a drain FSM.
- Provides PC redirect, an interrupt acknowledge, a bus-stall watchdog and a stall-cycle performance counter.

Parameters:
- ADDR_WIDTH, 32, width of PC/redirect addresses
- TIMEOUT_CYCLES, 256, consecutive MEM stall cycles before bus timeout (≥2)
- CNT_WIDTH, 32, width of stall performance counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- stallreq_id_i  in  1  load-use hazard from ID
- stallreq_exe_i  in  1  multi-cycle EXE op busy
- stallreq_mem_i  in  1  MEM bus wait
- jump_i  in  1  taken branch/jump resolved in EXE
- jump_addr_i  in  ADDR_WIDTH  jump target
- int_req_i  in  1  level interrupt request (already masked by CSR logic)
- int_addr_i  in  ADDR_WIDTH  trap vector
- stall_o  out  6  stall vector; bit0 pc, 1 if_id, 2 id_exe, 3 exe_mem, 4 mem_wb, 5 wb; 1 = STOP
- flush_jump_o  out  1  flush IF/ID and ID/EXE for a jump
- flush_int_o  out  1  flush all stages for trap entry
- redirect_o  out  1  PC load strobe
- redirect_addr_o  out  ADDR_WIDTH  PC load value
- int_ack_o  out  1  one-cycle interrupt accept pulse
- bus_timeout_o  out  1  one-cycle watchdog pulse
- stall_cnt_o  out  CNT_WIDTH  count of cycles with stall_o[0]=1

Behaviour:
- Reset (rst_i=0, asynchronous):
  - FSM goes to IDLE; watchdog counter and stall_cnt_o clear to 0.
  - All outputs are 0 while reset is asserted, including combinational ones.
- Stall vector (combinational, priority MEM > EXE > ID):
  - stallreq_mem_i → 6'b011111
  - else stallreq_exe_i → 6'b001111
  - else stallreq_id_i → 6'b000111 (id_exe STOP with exe_mem NOSTOP, which inserts a bubble)
  - else 6'b000000
  - In TRAP state stall_o is forced to 0.
- Jump flush (combinational):
  - flush_jump_o = jump_i & ~stall_o[3] & (state≠TRAP).
  - While flush_jump_o=1: redirect_o=1 and redirect_addr_o=jump_addr_i.
  - If EXE/MEM is stalled, the flush waits; jump_i is held by EXE until the stall clears.
- Interrupt FSM (registered states IDLE, DRAIN, TRAP, WAIT_CLR):
  - IDLE → DRAIN when int_req_i=1.
  - DRAIN → TRAP when stall_o[3]=0 and flush_jump_o=0. The jump takes priority, and the interrupt is taken on a later cycle.
  - DRAIN → IDLE if int_req_i drops before entry (request withdrawn, no ack).
  - TRAP lasts exactly one cycle:
    - flush_int_o=1, int_ack_o=1, redirect_o=1, redirect_addr_o=int_addr_i
    - then → WAIT_CLR
  - WAIT_CLR → IDLE when int_req_i=0. No re-entry while the request is still high.
  - Redirect mux priority: TRAP over jump.
- Watchdog:
  - Counter increments each cycle stallreq_mem_i=1 and clears when it is 0.
  - When the count reaches TIMEOUT_CYCLES-1 with stallreq_mem_i still 1, bus_timeout_o pulses for 1 cycle (registered) and the counter clears to 0. A continued stall re-arms it.
- Perf counter:
  - stall_cnt_o increments on every clock with stall_o[0]=1.
  - Wraps modulo 2^CNT_WIDTH with no saturation.
- Simultaneous events:
  - jump_i together with stallreq_mem_i → no flush, stall 011111.
  - int_req_i rising in the same cycle as a jump flush → FSM enters DRAIN; TRAP follows one cycle later at the earliest.
- Reset mid-TRAP/DRAIN: the FSM aborts to IDLE, with no ack and no flush after reset.

Test Plan:
- Load-use: stallreq_id_i=1 for 1 cycle → stall_o=6'b000111 that cycle, then 0; stall_cnt_o increments by 1.
- Priority: all three stallreq=1 → stall_o=6'b011111; drop mem only → 6'b001111.
- Jump under stall: jump_i=1, jump_addr_i=0x80000040, stallreq_exe_i=1 for 3 cycles → flush_jump_o=0 for those cycles; on the 4th cycle flush_jump_o=1, redirect_addr_o=0x80000040.
- Interrupt drain: int_req_i=1 while stallreq_mem_i=1 for 2 cycles, int_addr_i=0x80000100 → after the stall clears, a single cycle of flush_int_o=int_ack_o=redirect_o=1 with redirect_addr_o=0x80000100. Holding int_req_i produces no second ack until it is deasserted and reasserted.
- Watchdog: TIMEOUT_CYCLES=4, stallreq_mem_i held 10 cycles → bus_timeout_o pulses twice, 4 cycles apart.
- Async reset: assert rst_i=0 mid-DRAIN between clock edges → all outputs 0 immediately; after release, no ack occurs unless int_req_i is reasserted from 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall priority, jump/trap flush, interrupt drain FSM,
// bus-stall watchdog and stall-cycle performance counter.
module pipe_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stallreq_id_i,
  input  logic                  stallreq_exe_i,
  input  logic                  stallreq_mem_i,
  input  logic                  jump_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  int_req_i,
  input  logic [ADDR_WIDTH-1:0] int_addr_i,
  output logic [5:0]            stall_o,
  output logic                  flush_jump_o,
  output logic                  flush_int_o,
  output logic                  redirect_o,
  output logic [ADDR_WIDTH-1:0] redirect_addr_o,
  output logic                  int_ack_o,
  output logic                  bus_timeout_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDrain, StTrap, StWaitClr} state_t;

  state_t               state_q, state_d;
  logic [WdW-1:0]       wd_q;
  logic                 timeout_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic [5:0] stall_raw;
  logic [5:0] stall_int;
  logic       in_trap;
  logic       flush_jump_int;

  // Priority MEM > EXE > ID; the ID case stops id_exe but lets exe_mem run (bubble).
  always_comb begin
    stall_raw = 6'b000000;
    if (stallreq_mem_i) begin
      stall_raw = 6'b011111;
    end else if (stallreq_exe_i) begin
      stall_raw = 6'b001111;
    end else if (stallreq_id_i) begin
      stall_raw = 6'b000111;
    end
  end

  always_comb begin
    in_trap        = (state_q == StTrap);
    stall_int      = in_trap ? 6'b000000 : stall_raw;
    flush_jump_int = jump_i & ~stall_int[3] & ~in_trap;
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a pending jump flush is allowed to go first.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (int_req_i) state_d = StDrain;
      end
      StDrain: begin
        if (!int_req_i) begin
          state_d = StIdle;
        end else if (!stall_int[3] && !flush_jump_int) begin
          state_d = StTrap;
        end
      end
      StTrap: begin
        state_d = StWaitClr;
      end
      StWaitClr: begin
        if (!int_req_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; combinational ones are forced low while reset is held.
  always_comb begin
    stall_o         = 6'b000000;
    flush_jump_o    = 1'b0;
    flush_int_o     = 1'b0;
    int_ack_o       = 1'b0;
    redirect_o      = 1'b0;
    redirect_addr_o = '0;
    if (rst_i) begin
      stall_o      = stall_int;
      flush_jump_o = flush_jump_int;
      flush_int_o  = in_trap;
      int_ack_o    = in_trap;
      if (in_trap) begin
        redirect_o      = 1'b1;
        redirect_addr_o = int_addr_i;
      end else if (flush_jump_int) begin
        redirect_o      = 1'b1;
        redirect_addr_o = jump_addr_i;
      end
    end
  end

  // Watchdog: counts consecutive MEM wait cycles, fires and restarts at the limit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (!stallreq_mem_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (wd_q == WdLast) begin
      wd_q      <= '0;
      timeout_q <= 1'b1;
    end else begin
      wd_q      <= wd_q + WdW'(1);
      timeout_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (stall_int[0]) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus_timeout_o = timeout_q;
  assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a per-cycle behavioural model and literal spot checks.
module tb_pipe_ctrl;

  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 4;
  localparam int unsigned CW  = 4;

  logic          clk;
  logic          rst_i;
  logic          stallreq_id_i, stallreq_exe_i, stallreq_mem_i;
  logic          jump_i, int_req_i;
  logic [AW-1:0] jump_addr_i, int_addr_i;
  logic [5:0]    stall_o;
  logic          flush_jump_o, flush_int_o, redirect_o, int_ack_o, bus_timeout_o;
  logic [AW-1:0] redirect_addr_o;
  logic [CW-1:0] stall_cnt_o;

  pipe_ctrl #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TMO),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_exe_i (stallreq_exe_i),
    .stallreq_mem_i (stallreq_mem_i),
    .jump_i         (jump_i),
    .jump_addr_i    (jump_addr_i),
    .int_req_i      (int_req_i),
    .int_addr_i     (int_addr_i),
    .stall_o        (stall_o),
    .flush_jump_o   (flush_jump_o),
    .flush_int_o    (flush_int_o),
    .redirect_o     (redirect_o),
    .redirect_addr_o(redirect_addr_o),
    .int_ack_o      (int_ack_o),
    .bus_timeout_o  (bus_timeout_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Interrupt bookkeeping: a request is "pending" until taken or withdrawn; the trap cycle
  // itself; then "waiting" until the request line is seen low.
  logic m_pend, m_trap, m_wait;
  int   m_run;   // length of the current unbroken MEM-wait run
  logic m_tmo;
  int   m_cnt;   // total stalled cycles

  function automatic logic [5:0] exp_stall();
    if (!rst_i || m_trap) return 6'b000000;
    if (stallreq_mem_i) return 6'b011111;
    if (stallreq_exe_i) return 6'b001111;
    if (stallreq_id_i) return 6'b000111;
    return 6'b000000;
  endfunction

  function automatic logic exp_fj();
    logic [5:0] s;
    s = exp_stall();
    return rst_i && jump_i && !s[3] && !m_trap;
  endfunction

  function automatic logic [AW-1:0] exp_addr();
    if (!rst_i) return '0;
    if (m_trap) return int_addr_i;
    if (exp_fj()) return jump_addr_i;
    return '0;
  endfunction

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_pend <= 1'b0;
      m_trap <= 1'b0;
      m_wait <= 1'b0;
      m_run  <= 0;
      m_tmo  <= 1'b0;
      m_cnt  <= 0;
    end else begin
      if (exp_stall() != 6'b000000) m_cnt <= (m_cnt + 1) % (1 << CW);
      if (stallreq_mem_i) begin
        m_run <= m_run + 1;
        m_tmo <= ((m_run + 1) % TMO) == 0;
      end else begin
        m_run <= 0;
        m_tmo <= 1'b0;
      end
      if (m_trap) begin
        m_trap <= 1'b0;
        m_wait <= 1'b1;
      end else if (m_wait) begin
        if (!int_req_i) m_wait <= 1'b0;
      end else if (m_pend) begin
        if (!int_req_i) begin
          m_pend <= 1'b0;
        end else if (!stallreq_mem_i && !stallreq_exe_i && !exp_fj()) begin
          m_pend <= 1'b0;
          m_trap <= 1'b1;
        end
      end else if (int_req_i) begin
        m_pend <= 1'b1;
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("stall_o", 64'(stall_o), 64'(exp_stall()));
    chk("flush_jump_o", 64'(flush_jump_o), 64'(exp_fj()));
    chk("flush_int_o", 64'(flush_int_o), 64'(rst_i && m_trap));
    chk("int_ack_o", 64'(int_ack_o), 64'(rst_i && m_trap));
    chk("redirect_o", 64'(redirect_o), 64'(rst_i && (m_trap || exp_fj())));
    chk("redirect_addr_o", 64'(redirect_addr_o), 64'(exp_addr()));
    chk("bus_timeout_o", 64'(bus_timeout_o), 64'(m_tmo));
    chk("stall_cnt_o", 64'(stall_cnt_o), 64'(m_cnt));
  end

  // Event monitors for the literal checks.
  int cyc_no = 0;
  int ack_seen = 0;
  int tmo_n = 0;
  int tmo_last = 0;
  int tmo_gap = 0;
  always @(posedge clk) cyc_no <= cyc_no + 1;
  always @(negedge clk) begin
    if (int_ack_o) ack_seen <= ack_seen + 1;
    if (bus_timeout_o) begin
      tmo_n    <= tmo_n + 1;
      tmo_gap  <= cyc_no - tmo_last;
      tmo_last <= cyc_no;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int a0;

  initial begin
    rst_i = 1'b1;
    {stallreq_id_i, stallreq_exe_i, stallreq_mem_i, jump_i, int_req_i} = '0;
    jump_addr_i = '0;
    int_addr_i  = '0;
    #1 rst_i = 1'b0;
    #1;
    chk("reset stall_o", 64'(stall_o), 64'h0);
    chk("reset stall_cnt_o", 64'(stall_cnt_o), 64'h0);
    chk("reset redirect_o", 64'(redirect_o), 64'h0);
    #10 rst_i = 1'b1;

    // Load-use bubble
    cyc(); stallreq_id_i = 1'b1; #1;
    chk("load-use stall_o", 64'(stall_o), 64'h07);
    cyc(); stallreq_id_i = 1'b0; #1;
    chk("load-use release", 64'(stall_o), 64'h00);
    chk("load-use stall_cnt", 64'(stall_cnt_o), 64'h1);

    // Priority
    cyc(); {stallreq_id_i, stallreq_exe_i, stallreq_mem_i} = 3'b111; #1;
    chk("prio all", 64'(stall_o), 64'h1F);
    cyc(); stallreq_mem_i = 1'b0; #1;
    chk("prio exe", 64'(stall_o), 64'h0F);
    cyc(); {stallreq_id_i, stallreq_exe_i} = 2'b00;

    // Jump held under an EXE stall
    cyc(); jump_i = 1'b1; jump_addr_i = 32'h8000_0040; stallreq_exe_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("jump held", 64'(flush_jump_o), 64'h0);
      cyc();
    end
    stallreq_exe_i = 1'b0; #1;
    chk("jump flush", 64'(flush_jump_o), 64'h1);
    chk("jump redirect", 64'(redirect_o), 64'h1);
    chk("jump addr", 64'(redirect_addr_o), 64'h8000_0040);
    cyc(); jump_i = 1'b0;

    // Interrupt drained behind a MEM stall
    a0 = ack_seen;
    cyc(); int_req_i = 1'b1; stallreq_mem_i = 1'b1; int_addr_i = 32'h8000_0100;
    cyc();
    cyc(); stallreq_mem_i = 1'b0; #1;
    chk("drain no ack", 64'(int_ack_o), 64'h0);
    cyc(); #1;
    chk("trap ack", 64'(int_ack_o), 64'h1);
    chk("trap flush", 64'(flush_int_o), 64'h1);
    chk("trap addr", 64'(redirect_addr_o), 64'h8000_0100);
    repeat (5) cyc();
    chk("held req single ack", 64'(ack_seen - a0), 64'h1);
    int_req_i = 1'b0;
    cyc(); int_req_i = 1'b1;
    repeat (4) cyc();
    chk("re-req second ack", 64'(ack_seen - a0), 64'h2);
    int_req_i = 1'b0;
    cyc(); cyc();

    // Jump together with MEM stall
    jump_i = 1'b1; stallreq_mem_i = 1'b1; #1;
    chk("jump+mem flush", 64'(flush_jump_o), 64'h0);
    chk("jump+mem stall", 64'(stall_o), 64'h1F);
    cyc(); jump_i = 1'b0; stallreq_mem_i = 1'b0;

    // Interrupt rising with a jump flush: jump first, trap later
    cyc(); jump_i = 1'b1; int_req_i = 1'b1; jump_addr_i = 32'h0000_1234; #1;
    chk("jump+int flush", 64'(flush_jump_o), 64'h1);
    chk("jump+int addr", 64'(redirect_addr_o), 64'h0000_1234);
    cyc(); jump_i = 1'b0; #1;
    chk("jump+int drain", 64'(int_ack_o), 64'h0);
    cyc(); #1;
    chk("jump+int trap", 64'(int_ack_o), 64'h1);
    cyc(); int_req_i = 1'b0;
    cyc(); cyc();

    // Watchdog
    stallreq_mem_i = 1'b1;
    repeat (10) cyc();
    stallreq_mem_i = 1'b0;
    cyc(); cyc();
    chk("timeout count", 64'(tmo_n), 64'h2);
    chk("timeout gap", 64'(tmo_gap), 64'h4);

    // Asynchronous reset in the middle of DRAIN
    cyc(); int_req_i = 1'b1; stallreq_mem_i = 1'b1;
    cyc(); #2 rst_i = 1'b0; #1;
    chk("async stall_o", 64'(stall_o), 64'h0);
    chk("async flush_int", 64'(flush_int_o), 64'h0);
    chk("async stall_cnt", 64'(stall_cnt_o), 64'h0);
    int_req_i = 1'b0; stallreq_mem_i = 1'b0;
    cyc(); cyc(); rst_i = 1'b1;
    a0 = ack_seen;
    repeat (5) cyc();
    chk("post-reset no ack", 64'(ack_seen - a0), 64'h0);
    int_req_i = 1'b1;
    repeat (4) cyc();
    chk("post-reset reassert ack", 64'(ack_seen - a0), 64'h1);
    int_req_i = 1'b0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
